// File: rtl/ex_muldiv.sv
// Iterative XLEN-bit multiply/divide unit for the EX stage: shift-add multiply, restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN: trivial/special operations bypass iteration and finish right after capture.
module ex_muldiv #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_op;
  logic [4:0]          r_rd;
  logic                r_neg_a;
  logic                r_neg_b;
  logic                r_bzero;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_opb;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_done;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd_out;

  logic                w_signed_in;
  logic                w_neg_a_in;
  logic                w_neg_b_in;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [XLEN:0]       w_div_shift;
  logic [XLEN:0]       w_div_diff;
  logic [2*XLEN-1:0]   w_div_next;
  logic [2*XLEN-1:0]   w_prod_fix;
  logic [XLEN-1:0]     w_quot_fix;
  logic [XLEN-1:0]     w_rem_fix;
  logic [XLEN-1:0]     w_fix_res;

  assign w_signed_in = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_neg_a_in  = w_signed_in & a[XLEN-1];
  assign w_neg_b_in  = w_signed_in & b[XLEN-1];
  assign w_abs_a     = w_neg_a_in ? (~a + {{(XLEN-1){1'b0}}, 1'b1}) : a;
  assign w_abs_b     = w_neg_b_in ? (~b + {{(XLEN-1){1'b0}}, 1'b1}) : b;

  // Multiply: multiplier sits in the low half and shifts out as the partial sum shifts in.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: remainder in the high half, dividend/quotient bits shift through the low half.
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_next  = w_div_diff[XLEN] ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                        : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? (~r_acc + {{(2*XLEN-1){1'b0}}, 1'b1}) : r_acc;
  assign w_quot_fix = (r_neg_a ^ r_neg_b) ? (~r_acc[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                                          : r_acc[XLEN-1:0];
  assign w_rem_fix  = r_neg_a ? (~r_acc[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                              : r_acc[2*XLEN-1:XLEN];

  // Final result selection with sign correction and divide-by-zero override.
  always_comb begin
    w_fix_res = {XLEN{1'b0}};
    if (r_op[2]) begin
      if (r_bzero) begin
        w_fix_res = r_op[1] ? r_a : {XLEN{1'b1}};
      end else begin
        w_fix_res = r_op[1] ? w_rem_fix : w_quot_fix;
      end
    end else begin
      case (r_op[1:0])
        2'b01, 2'b10: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
        default:      w_fix_res = w_prod_fix[XLEN-1:0];
      endcase
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            w_ovf_in;
  logic            w_early;
  logic [XLEN-1:0] w_early_res;

  assign w_ovf_in = ((op == 3'b100) || (op == 3'b110)) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
  assign w_early  = op[2] ? ((b == {XLEN{1'b0}}) || w_ovf_in)
                          : ((a == {XLEN{1'b0}}) || (b == {XLEN{1'b0}}));

  // Special-case result computed straight from the ID/EX operands.
  always_comb begin
    w_early_res = {XLEN{1'b0}};
    if (!op[2]) begin
      w_early_res = {XLEN{1'b0}};
    end else if (b == {XLEN{1'b0}}) begin
      w_early_res = op[1] ? a : {XLEN{1'b1}};
    end else begin
      w_early_res = op[1] ? {XLEN{1'b0}} : a;
    end
  end
`endif

  // Control FSM and datapath registers; flush overrides every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_op     <= 3'b000;
      r_rd     <= 5'd0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_bzero  <= 1'b0;
      r_a      <= {XLEN{1'b0}};
      r_opb    <= {XLEN{1'b0}};
      r_acc    <= {(2*XLEN){1'b0}};
      r_done   <= 1'b0;
      r_result <= {XLEN{1'b0}};
      r_rd_out <= 5'd0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_rd    <= rd_in;
            r_neg_a <= w_neg_a_in;
            r_neg_b <= w_neg_b_in;
            r_bzero <= (b == {XLEN{1'b0}});
            r_a     <= a;
            r_opb   <= w_abs_b;
            r_acc   <= {{XLEN{1'b0}}, w_abs_a};
            r_cnt   <= {CNT_W{1'b0}};
`ifdef MULDIV_EARLY_OUT_EN
            if (w_early) begin
              r_result <= w_early_res;
              r_rd_out <= rd_in;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
`else
            r_state <= S_CALC;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_cnt == CNT_W'(XLEN-1)) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_rd_out <= r_rd;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall  = ((r_state == S_IDLE) & start) | (r_state == S_CALC) | (r_state == S_FIX);
  assign done   = r_done;
  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: latency, stall length, results, flush and reset behaviour.
module tb_ex_muldiv;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        stall;
  logic        done;
  logic [63:0] result;
  logic [4:0]  rd_out;

  int          tests;
  int          fails;
  logic [63:0] last_res;
  logic [4:0]  last_rd;

  ex_muldiv #(.XLEN(64), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_in(rd_in), .flush(flush), .stall(stall), .done(done),
    .result(result), .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op from an IDLE negedge and follow it to its done pulse.
  task automatic do_op(input string tag, input logic [2:0] op_i, input logic [63:0] a_i,
                       input logic [63:0] b_i, input logic [4:0] rd_i,
                       input logic [63:0] exp_res, input bit sp, input bit poke);
    int k;
    int stl;
    int exp_lat;
    exp_lat = (EARLY && sp) ? 1 : 66;
    op = op_i; a = a_i; b = b_i; rd_in = rd_i; start = 1'b1;
    #1;
    check({tag, "_stall_req"}, {63'd0, stall}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    stl = 1;
    while (done !== 1'b1 && k < 200) begin
      stl = stl + int'(stall);
      if (poke && k == 10) begin
        start = 1'b1; rd_in = 5'd31; op = 3'b000; a = 64'd1; b = 64'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_latency"}, 64'(k), 64'(exp_lat));
    check({tag, "_stall_cycles"}, 64'(stl), 64'(exp_lat == 1 ? 1 : 66));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_rd_out"}, {59'd0, rd_out}, {59'd0, rd_i});
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    last_res = exp_res;
    last_rd  = rd_i;
  endtask

  initial begin
    int nd;
    tests = 0; fails = 0;
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    op = 3'b000; a = 64'd0; b = 64'd0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_rd_out", {59'd0, rd_out}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    do_op("mul3x4", 3'b000, 64'd3, 64'd4, 5'd3, 64'd12, 1'b0, 1'b0);

    // Reset asserted in the middle of a multiply.
    op = 3'b000; a = 64'd9; b = 64'd9; rd_in = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_rd_out", {59'd0, rd_out}, 64'd0);
    check("midrst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    do_op("mul7x6", 3'b000, 64'd7, 64'd6, 5'd5, 64'd42, 1'b0, 1'b0);
    do_op("mulh_m1", 3'b001, ONES, ONES, 5'd6, 64'd0, 1'b0, 1'b0);
    do_op("mulhu_m1", 3'b010, ONES, ONES, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    do_op("mul_min2", 3'b000, MIN, 64'd2, 5'd10, 64'd0, 1'b0, 1'b0);
    do_op("rsv_as_mul", 3'b011, 64'd5, 64'd9, 5'd11, 64'd45, 1'b0, 1'b0);
    do_op("mul_zero", 3'b000, 64'd0, 64'd1234, 5'd12, 64'd0, 1'b1, 1'b0);
    do_op("div_m7_2", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    do_op("rem_m7_2", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd14, ONES, 1'b0, 1'b0);
    do_op("divu_100_7", 3'b101, 64'd100, 64'd7, 5'd15, 64'd14, 1'b0, 1'b1);
    do_op("remu_100_7", 3'b111, 64'd100, 64'd7, 5'd16, 64'd2, 1'b0, 1'b0);
    do_op("div_by0", 3'b100, 64'd5, 64'd0, 5'd17, ONES, 1'b1, 1'b0);
    do_op("rem_by0", 3'b110, 64'd5, 64'd0, 5'd18, 64'd5, 1'b1, 1'b0);
    do_op("div_ovf", 3'b100, MIN, ONES, 5'd19, MIN, 1'b1, 1'b0);
    do_op("rem_ovf", 3'b110, MIN, ONES, 5'd20, 64'd0, 1'b1, 1'b0);

    // Flush a DIVU at iteration 30.
    op = 3'b101; a = 64'd1000; b = 64'd3; rd_in = 5'd21; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_stall", {63'd0, stall}, 64'd0);
    nd = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("flush_no_done", 64'(nd), 64'd0);
    check("flush_result_hold", result, last_res);
    check("flush_rd_hold", {59'd0, rd_out}, {59'd0, last_rd});

    do_op("after_flush", 3'b101, 64'd1000, 64'd3, 5'd22, 64'd333, 1'b0, 1'b0);
    do_op("b2b_first", 3'b000, 64'd11, 64'd13, 5'd23, 64'd143, 1'b0, 1'b0);
    do_op("b2b_second", 3'b111, 64'd1000, 64'd3, 5'd24, 64'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
